// File: rtl/led_anim_pkg.sv
// Shared definitions for the LED animation engine: pattern mode encodings,
// sweep direction and the default LED bank width.
package led_anim_pkg;

    typedef enum logic [1:0] {
        MODE_SCAN_L = 2'd0,
        MODE_SCAN_R = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int N_LED_DEF = 8;

endpackage

// File: rtl/led_pattern_engine.sv
// Steps one of four LED animations per accepted tick (or per step while paused),
// restarting on mode change and pulsing wrap when a pattern cycle completes.
module led_pattern_engine
    import led_anim_pkg::*;
#(
    parameter int N_LED = N_LED_DEF,
    parameter int CW    = $clog2(2 * N_LED)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [1:0]       mode,
    input  logic             pause,
    input  logic             step,
    output logic [N_LED-1:0] led,
    output logic             wrap
);

    localparam logic [CW-1:0] LAST_POS    = CW'(N_LED - 1);
    localparam logic [CW-1:0] PRE_LAST    = CW'(N_LED - 2);
    localparam logic [CW-1:0] FILL_LAST   = CW'(2 * N_LED - 1);
    localparam logic [CW-1:0] ONE         = CW'(1);
    localparam logic [N_LED-1:0] LED_INIT = {{(N_LED-1){1'b0}}, 1'b1};

    // Complete animation state; led is a registered function of it.
    typedef struct packed {
        mode_e         mode_q;
        logic [CW-1:0] cnt;
        dir_e          dir;
    } anim_state_t;

    anim_state_t       state_q, state_d;
    logic [N_LED-1:0]  led_d;
    logic              wrap_d;
    logic              adv;
    mode_e             mode_in;

    // FILL: cnt < N lights the low cnt+1 bits; cnt >= N keeps the top 2N-1-cnt bits.
    function automatic logic [N_LED-1:0] pattern(input mode_e m, input logic [CW-1:0] c);
        int ci;
        ci      = int'(c);
        pattern = '0;
        for (int i = 0; i < N_LED; i++) begin
            case (m)
                MODE_SCAN_L: pattern[i] = (i == ci);
                MODE_SCAN_R: pattern[i] = (i == N_LED - 1 - ci);
                MODE_BOUNCE: pattern[i] = (i == ci);
                MODE_FILL:   pattern[i] = (ci < N_LED) ? (i <= ci) : (i >= ci - N_LED + 1);
                default:     pattern[i] = 1'b0;
            endcase
        end
    endfunction

    assign mode_in = mode_e'(mode);
    assign adv     = pause ? step : tick;

    always_comb begin
        state_d = state_q;
        led_d   = led;
        wrap_d  = 1'b0;
        if (mode_in != state_q.mode_q) begin
            state_d.mode_q = mode_in;
            state_d.cnt    = '0;
            state_d.dir    = DIR_UP;
            led_d          = pattern(mode_in, '0);
        end else if (adv) begin
            case (state_q.mode_q)
                MODE_SCAN_L, MODE_SCAN_R: begin
                    if (state_q.cnt == LAST_POS) begin
                        state_d.cnt = '0;
                        wrap_d      = 1'b1;
                    end else begin
                        state_d.cnt = state_q.cnt + ONE;
                    end
                end
                MODE_BOUNCE: begin
                    // Direction flips on arrival at an end so end bits are shown once.
                    if (state_q.dir == DIR_UP) begin
                        state_d.cnt = state_q.cnt + ONE;
                        if (state_q.cnt == PRE_LAST) state_d.dir = DIR_DOWN;
                    end else begin
                        state_d.cnt = state_q.cnt - ONE;
                        if (state_q.cnt == ONE) begin
                            state_d.dir = DIR_UP;
                            wrap_d      = 1'b1;
                        end
                    end
                end
                MODE_FILL: begin
                    if (state_q.cnt == FILL_LAST) begin
                        state_d.cnt = '0;
                        wrap_d      = 1'b1;
                    end else begin
                        state_d.cnt = state_q.cnt + ONE;
                    end
                end
                default: ;
            endcase
            led_d = pattern(state_q.mode_q, state_d.cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q.mode_q <= MODE_SCAN_L;
            state_q.cnt    <= '0;
            state_q.dir    <= DIR_UP;
            led            <= LED_INIT;
            wrap           <= 1'b0;
        end else begin
            state_q <= state_d;
            led     <= led_d;
            wrap    <= wrap_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Bench for led_pattern_engine: a sequence-table reference model (mode, step index)
// tracks the expected LED value and wrap pulse for every cycle.
module tb_led_pattern_engine;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         tick = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic         pause = 1'b0;
    logic         step = 1'b0;
    logic [N-1:0] led;
    logic         wrap;

    int total = 0;
    int bad   = 0;

    int m_mode = 0;
    int m_idx  = 0;
    bit m_wrap = 1'b0;

    led_pattern_engine #(.N_LED(N)) dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .mode  (mode),
        .pause (pause),
        .step  (step),
        .led   (led),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    function automatic int seq_len(input int m);
        case (m)
            2:       seq_len = 2 * N - 2;
            3:       seq_len = 2 * N;
            default: seq_len = N;
        endcase
    endfunction

    // k-th LED value of each animation, straight from the pattern definitions.
    function automatic logic [N-1:0] exp_led(input int m, input int k);
        int v;
        case (m)
            0: v = 1 << k;
            1: v = 1 << (N - 1 - k);
            2: v = 1 << ((k < N) ? k : (2 * N - 2 - k));
            default: v = (k < N) ? ((1 << (k + 1)) - 1)
                                 : (((1 << N) - 1) & ~((1 << (k - N + 1)) - 1));
        endcase
        exp_led = N'(v);
    endfunction

    task automatic drive(input logic r, input logic t, input logic s, input logic p,
                         input logic [1:0] m);
        reset = r; tick = t; step = s; pause = p; mode = m;
        @(posedge clk);
        if (!r) begin
            m_mode = 0; m_idx = 0; m_wrap = 1'b0;
        end else if (int'(m) != m_mode) begin
            m_mode = int'(m); m_idx = 0; m_wrap = 1'b0;
        end else if (p ? s : t) begin
            m_idx  = (m_idx + 1) % seq_len(m_mode);
            m_wrap = (m_idx == 0);
        end else begin
            m_wrap = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            total++;
            if (led !== 8'h01 || wrap !== 1'b0) begin
                bad++;
                $display("FAIL reset led=%h wrap=%b want led=01 wrap=0", led, wrap);
            end
        end
    endtask

    // Runs each mode for two full cycles with a tick every 4 clocks.
    task automatic test_patterns();
        int wraps;
        for (int m = 0; m < 4; m++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 2'(m));
            total++;
            if (led !== exp_led(m, 0) || wrap !== 1'b0) begin
                bad++;
                $display("FAIL start mode=%0d led=%h wrap=%b want led=%h wrap=0",
                         m, led, wrap, exp_led(m, 0));
            end
            wraps = 0;
            for (int c = 0; c < 4 * 2 * seq_len(m); c++) begin
                drive(1'b1, (c % 4) == 0, 1'b0, 1'b0, 2'(m));
                if (wrap === 1'b1) wraps++;
                total++;
                if (led !== exp_led(m_mode, m_idx) || wrap !== m_wrap) begin
                    bad++;
                    $display("FAIL pattern mode=%0d c=%0d led=%h wrap=%b want led=%h wrap=%b",
                             m, c, led, wrap, exp_led(m_mode, m_idx), m_wrap);
                end
            end
            total++;
            if (wraps != 2) begin
                bad++;
                $display("FAIL wrap_count mode=%0d got=%0d want=2", m, wraps);
            end
        end
    endtask

    task automatic test_pause();
        logic [N-1:0] held;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
        held = led;
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, (c % 4) == 0, 1'b0, 1'b1, 2'd3);
            total++;
            if (led !== held || wrap !== 1'b0) begin
                bad++;
                $display("FAIL pause_hold led=%h wrap=%b want led=%h wrap=0", led, wrap, held);
            end
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd3);
        total++;
        if (led !== exp_led(m_mode, m_idx) || led !== 8'h07) begin
            bad++;
            $display("FAIL pause_step led=%h want=07", led);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd3);
        total++;
        if (led !== 8'h0F) begin
            bad++;
            $display("FAIL step_and_tick led=%h want=0f", led);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 2'd3);
        total++;
        if (led !== 8'h0F || wrap !== 1'b0) begin
            bad++;
            $display("FAIL step_unpaused led=%h wrap=%b want led=0f wrap=0", led, wrap);
        end
    endtask

    task automatic test_mode_switch();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int c = 0; c < 16; c++) drive(1'b1, (c % 4) == 0, 1'b0, 1'b0, 2'd0);
        total++;
        if (led !== 8'h10) begin
            bad++;
            $display("FAIL switch_setup led=%h want=10", led);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
        total++;
        if (led !== 8'h80 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL switch_restart led=%h wrap=%b want led=80 wrap=0", led, wrap);
        end
        for (int c = 0; c < 3; c++) drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
        total++;
        if (led !== 8'h40 || led !== exp_led(m_mode, m_idx)) begin
            bad++;
            $display("FAIL switch_next led=%h want=40", led);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        for (int c = 0; c < 36; c++) drive(1'b1, (c % 4) == 0, 1'b0, 1'b0, 2'd2);
        total++;
        if (led !== 8'h20) begin
            bad++;
            $display("FAIL mid_setup led=%h want=20", led);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        total++;
        if (led !== 8'h01 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset led=%h wrap=%b want led=01 wrap=0", led, wrap);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
        total++;
        if (led !== 8'h01 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_restart led=%h wrap=%b want led=01 wrap=0", led, wrap);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
        total++;
        if (led !== 8'h02) begin
            bad++;
            $display("FAIL post_reset_step led=%h want=02", led);
        end
    endtask

    task automatic test_random();
        logic [1:0] m;
        logic       p;
        m = 2'(m_mode);
        p = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 49) == 0) m = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) p = ~p;
            drive($urandom_range(0, 199) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, p, m);
            total++;
            if (led !== exp_led(m_mode, m_idx) || wrap !== m_wrap) begin
                bad++;
                $display("FAIL random c=%0d mode=%0d led=%h wrap=%b want led=%h wrap=%b",
                         c, m_mode, led, wrap, exp_led(m_mode, m_idx), m_wrap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_pause();
        test_mode_switch();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
